// File: rtl/dmem_responder.sv
// Data-memory responder for the MIPS M stage: zero-wait stores, fixed-latency loads
// that freeze the pipeline while outstanding, and one-cycle fault reporting.
module dmem_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memreadM,
    input  logic        memwriteM,
    input  logic [31:0] addrM,
    input  logic [31:0] wdataM,
    output logic [31:0] rdataM,
    output logic        stallM,
    output logic        rvalidM,
    output logic        errM
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] word_idx;
    logic [AW-1:0] load_idx;
    logic [3:0]    count;
    logic [31:0]   rdata_q;
    logic          legal;
    logic          accept;
    logic          do_store;
    logic          do_load;
    logic          bad_load;

    assign word_idx = addrM[AW+1:2];
    assign legal    = (addrM[1:0] == 2'b00) && (addrM[31:AW+2] == '0);

    // Requests are only decoded in IDLE; a reset cycle never starts a new access.
    assign accept   = (state == IDLE) && !reset;
    assign do_store = accept && memwriteM && legal;
    assign do_load  = accept && memreadM && !memwriteM && legal;
    assign bad_load = accept && memreadM && !memwriteM && !legal;

    assign errM    = accept && (memreadM || memwriteM) && (!legal || (memreadM && memwriteM));
    assign stallM  = do_load || (state == BUSY);
    assign rvalidM = ((state == DONE) && !reset) || bad_load;
    assign rdataM  = bad_load ? 32'd0 : rdata_q;

    always_ff @(posedge clk) begin
        if (do_store) begin
            mem[word_idx] <= wdataM;
        end
    end

    // The read of the array happens on the edge that enters DONE, so a store one
    // instruction earlier is always visible to the load.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            count   <= 4'd0;
            rdata_q <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (do_load) begin
                        load_idx <= word_idx;
                        count    <= 4'(LATENCY - 1);
                        if (LATENCY > 1) begin
                            state <= BUSY;
                        end else begin
                            state   <= DONE;
                            rdata_q <= mem[word_idx];
                        end
                    end else if (bad_load) begin
                        rdata_q <= 32'd0;
                    end
                end
                BUSY: begin
                    count <= count - 4'd1;
                    if (count == 4'd1) begin
                        state   <= DONE;
                        rdata_q <= mem[load_idx];
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: five responders with different load latencies, directed
// vector table, a mid-load reset sequence and randomized traffic vs a word-array model.
module tb_dmem_responder;

    localparam int NDUT = 5;

    typedef struct {
        int          op;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          experr;
        logic [31:0] expdata;
    } vec_t;

    logic        clk;
    logic        reset     [NDUT];
    logic        memreadM  [NDUT];
    logic        memwriteM [NDUT];
    logic [31:0] addrM     [NDUT];
    logic [31:0] wdataM    [NDUT];
    logic [31:0] rdataM    [NDUT];
    logic        stallM    [NDUT];
    logic        rvalidM   [NDUT];
    logic        errM      [NDUT];

    logic [31:0] model    [NDUT][64];
    logic [31:0] lastdata [NDUT];
    int          errors;
    int          checks;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        dmem_responder #(
            .DEPTH(64),
            .LATENCY(g == 0 ? 1 : g == 1 ? 2 : g == 2 ? 3 : g == 3 ? 4 : 7)
        ) dut (
            .clk(clk),
            .reset(reset[g]),
            .memreadM(memreadM[g]),
            .memwriteM(memwriteM[g]),
            .addrM(addrM[g]),
            .wdataM(wdataM[g]),
            .rdataM(rdataM[g]),
            .stallM(stallM[g]),
            .rvalidM(rvalidM[g]),
            .errM(errM[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int latof(int k);
        int lats [NDUT] = '{1, 2, 3, 4, 7};
        return lats[k];
    endfunction

    function automatic bit legaladdr(logic [31:0] a);
        return (a[1:0] == 2'b00) && (a[31:8] == 24'd0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(string name, int k, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s dut%0d: got %h expected %h", name, k, act, exp);
        end
    endtask

    // Store: zero wait states, fault flag only for bad address or read/write conflict.
    task automatic doStore(int k, logic [31:0] addr, logic [31:0] data, bit both, bit experr);
        memwriteM[k] = 1'b1;
        memreadM[k]  = both;
        addrM[k]     = addr;
        wdataM[k]    = data;
        #1;
        checkOutput("store_stall", k, 32'(stallM[k]), 32'd0);
        checkOutput("store_err", k, 32'(errM[k]), 32'(experr));
        checkOutput("store_rvalid", k, 32'(rvalidM[k]), 32'd0);
        tick();
        memwriteM[k] = 1'b0;
        memreadM[k]  = 1'b0;
        if (legaladdr(addr)) model[k][addr[7:2]] = data;
    endtask

    task automatic doLoad(int k, logic [31:0] addr, logic [31:0] exp);
        int n;
        memreadM[k]  = 1'b1;
        memwriteM[k] = 1'b0;
        addrM[k]     = addr;
        #1;
        if (!legaladdr(addr)) begin
            checkOutput("badload_err", k, 32'(errM[k]), 32'd1);
            checkOutput("badload_stall", k, 32'(stallM[k]), 32'd0);
            checkOutput("badload_rvalid", k, 32'(rvalidM[k]), 32'd1);
            checkOutput("badload_rdata", k, rdataM[k], 32'd0);
            tick();
            memreadM[k] = 1'b0;
            #1;
            checkOutput("badload_after_rvalid", k, 32'(rvalidM[k]), 32'd0);
            checkOutput("badload_after_rdata", k, rdataM[k], 32'd0);
            lastdata[k] = 32'd0;
        end else begin
            checkOutput("load_err", k, 32'(errM[k]), 32'd0);
            checkOutput("load_req_rvalid", k, 32'(rvalidM[k]), 32'd0);
            n = 0;
            while (stallM[k] && n < 40) begin
                n++;
                tick();
            end
            checkOutput("load_stall_len", k, 32'(n), 32'(latof(k)));
            checkOutput("load_rvalid", k, 32'(rvalidM[k]), 32'd1);
            checkOutput("load_rdata", k, rdataM[k], exp);
            memreadM[k] = 1'b0;
            tick();
            checkOutput("load_after_rvalid", k, 32'(rvalidM[k]), 32'd0);
            checkOutput("load_after_stall", k, 32'(stallM[k]), 32'd0);
            checkOutput("load_after_rdata", k, rdataM[k], exp);
            lastdata[k] = exp;
        end
    endtask

    task automatic doIdle(int k);
        memreadM[k]  = 1'b0;
        memwriteM[k] = 1'b0;
        addrM[k]     = $urandom;
        #1;
        checkOutput("idle_stall", k, 32'(stallM[k]), 32'd0);
        checkOutput("idle_rvalid", k, 32'(rvalidM[k]), 32'd0);
        checkOutput("idle_err", k, 32'(errM[k]), 32'd0);
        checkOutput("idle_rdata", k, rdataM[k], lastdata[k]);
        tick();
    endtask

    // op: 0 store, 1 load, 2 simultaneous read+write.
    task automatic applyStimulus(int k, vec_t v);
        case (v.op)
            0: doStore(k, v.addr, v.wdata, 1'b0, v.experr);
            1: doLoad(k, v.addr, v.expdata);
            default: doStore(k, v.addr, v.wdata, 1'b1, v.experr);
        endcase
    endtask

    initial begin
        vec_t vecs [12];
        errors = 0;
        checks = 0;
        vecs[0]  = '{0, 32'h10,  32'hDEADBEEF, 1'b0, 32'h0};
        vecs[1]  = '{1, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF};
        vecs[2]  = '{0, 32'h04,  32'h12345678, 1'b0, 32'h0};
        vecs[3]  = '{1, 32'h04,  32'h0,        1'b0, 32'h12345678};
        vecs[4]  = '{0, 32'h08,  32'hA5A5A5A5, 1'b0, 32'h0};
        vecs[5]  = '{1, 32'h08,  32'h0,        1'b0, 32'hA5A5A5A5};
        vecs[6]  = '{0, 32'h00,  32'h11111111, 1'b0, 32'h0};
        vecs[7]  = '{1, 32'h13,  32'h0,        1'b1, 32'h0};
        vecs[8]  = '{0, 32'h100, 32'h0BADBAD0, 1'b1, 32'h0};
        vecs[9]  = '{1, 32'h00,  32'h0,        1'b0, 32'h11111111};
        vecs[10] = '{2, 32'h20,  32'h00000055, 1'b1, 32'h0};
        vecs[11] = '{1, 32'h20,  32'h0,        1'b0, 32'h00000055};

        for (int k = 0; k < NDUT; k++) begin
            reset[k] = 1'b1; memreadM[k] = 1'b0; memwriteM[k] = 1'b0;
            addrM[k] = 32'd0; wdataM[k] = 32'd0; lastdata[k] = 32'd0;
        end
        tick();
        tick();
        for (int k = 0; k < NDUT; k++) reset[k] = 1'b0;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            checkOutput("reset_rdata", k, rdataM[k], 32'd0);
            checkOutput("reset_stall", k, 32'(stallM[k]), 32'd0);
            checkOutput("reset_rvalid", k, 32'(rvalidM[k]), 32'd0);
            checkOutput("reset_err", k, 32'(errM[k]), 32'd0);
        end

        // Directed vectors on every latency variant.
        for (int k = 0; k < NDUT; k++)
            for (int i = 0; i < 12; i++) applyStimulus(k, vecs[i]);

        // Reset during the second BUSY cycle of a LATENCY=4 load.
        doStore(3, 32'h30, 32'h77777777, 1'b0, 1'b0);
        doLoad(3, 32'h30, 32'h77777777);
        memreadM[3] = 1'b1;
        addrM[3]    = 32'h30;
        #1;
        checkOutput("rst_req_stall", 3, 32'(stallM[3]), 32'd1);
        tick();
        tick();
        checkOutput("rst_busy2_stall", 3, 32'(stallM[3]), 32'd1);
        reset[3]    = 1'b1;
        memreadM[3] = 1'b0;
        #1;
        checkOutput("rst_cycle_rvalid", 3, 32'(rvalidM[3]), 32'd0);
        tick();
        reset[3] = 1'b0;
        #1;
        checkOutput("rst_after_stall", 3, 32'(stallM[3]), 32'd0);
        checkOutput("rst_after_rdata", 3, rdataM[3], 32'd0);
        lastdata[3] = 32'd0;
        for (int i = 0; i < 6; i++) begin
            checkOutput("rst_no_rvalid", 3, 32'(rvalidM[3]), 32'd0);
            tick();
        end
        doStore(3, 32'h0C, 32'hCAFEF00D, 1'b0, 1'b0);
        doLoad(3, 32'h0C, 32'hCAFEF00D);

        // Fill every word so random loads have defined data.
        for (int k = 0; k < NDUT; k++)
            for (int w = 0; w < 64; w++) doStore(k, 32'(w) << 2, $urandom, 1'b0, 1'b0);

        for (int k = 0; k < NDUT; k++) begin
            for (int i = 0; i < 60; i++) begin
                int          r;
                logic [31:0] a;
                r = $urandom_range(0, 9);
                a = 32'($urandom_range(0, 63)) << 2;
                if (r == 9 || (r >= 4 && r <= 7 && $urandom_range(0, 4) == 0)) begin
                    if ($urandom_range(0, 1) == 1) a = a | 32'($urandom_range(1, 3));
                    else a = a | (32'h100 << $urandom_range(0, 23));
                end
                if (r <= 3 || r == 9)
                    doLoad(k, a, legaladdr(a) ? model[k][a[7:2]] : 32'd0);
                else if (r <= 6)
                    doStore(k, a, $urandom, 1'b0, !legaladdr(a));
                else if (r == 7)
                    doStore(k, a, $urandom, 1'b1, 1'b1);
                else
                    doIdle(k);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
